// File: rtl/pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_pkg
//  Description : Shared types and helpers for the serial packet deserialiser:
//                state encoding, default word width and length-field width.
//  Revision    : 1.0  initial release
// ============================================================================
package pkt_pkg;

    // Deserialiser states: accumulate, drop overflow beats, hold result
    typedef enum logic [1:0] {
        ACC  = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int c_DEFAULT_MAX_LEN = 8;

    // Bits needed to represent a beat count in 0..max_len
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_deser.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_deser
//  Description : Assembles a 1-bit serial packet stream (valid/ready/last)
//                into one parallel word plus beat count, presented on a
//                valid/ready output handshake. Packets longer than MAX_LEN
//                beats are truncated and flagged with err_out.
//  Options     : PKT_DESER_B2B_EN - when defined, a beat may be accepted in
//                the same cycle the held word is consumed (zero bubble).
//  Revision    : 1.0  initial release
// ============================================================================
module pkt_deser
    import pkt_pkg::*;
#(
    parameter int MAX_LEN = c_DEFAULT_MAX_LEN,
    parameter int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    input  logic               data_in,
    input  logic               last_in,
    output logic               ready_in,
    output logic               valid_out,
    output logic [MAX_LEN-1:0] data_out,
    output logic [LEN_W-1:0]   len_out,
    output logic               err_out,
    input  logic               ready_out
);

    state_t             r_state;
    logic [LEN_W-1:0]   r_count;
    logic [MAX_LEN-1:0] r_word;
    logic               r_err;
    logic               r_valid_out;

    logic               w_ready_in;
    logic               w_accept;
    logic               w_fire;
    logic               w_at_last_slot;

    // Input readiness is a pure state decode so it never depends on valid_in
    always_comb begin
        w_ready_in = (r_state != HOLD);
`ifdef PKT_DESER_B2B_EN
        if (r_state == HOLD) begin
            w_ready_in = ready_out;
        end
`endif
    end

    assign w_accept       = valid_in && w_ready_in;
    assign w_fire         = r_valid_out && ready_out;
    assign w_at_last_slot = (r_count == LEN_W'(MAX_LEN - 1));

    // State, beat count, assembled word and registered output flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ACC;
            r_count     <= '0;
            r_word      <= '0;
            r_err       <= 1'b0;
            r_valid_out <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (r_count == LEN_W'(i)) begin
                                r_word[i] <= data_in;
                            end
                        end
                        r_count <= r_count + LEN_W'(1);
                        if (last_in) begin
                            r_state     <= HOLD;
                            r_valid_out <= 1'b1;
                        end else if (w_at_last_slot) begin
                            // Word is full but packet continues: discard the rest
                            r_state <= DROP;
                        end
                    end
                end

                DROP: begin
                    if (w_accept) begin
                        r_err <= 1'b1;
                        if (last_in) begin
                            r_state     <= HOLD;
                            r_valid_out <= 1'b1;
                        end
                    end
                end

                HOLD: begin
                    if (w_fire) begin
                        r_state     <= ACC;
                        r_valid_out <= 1'b0;
                        r_count     <= '0;
                        r_word      <= '0;
                        r_err       <= 1'b0;
`ifdef PKT_DESER_B2B_EN
                        // A beat taken in the fire cycle starts the next packet
                        if (w_accept) begin
                            r_word  <= MAX_LEN'(data_in);
                            r_count <= LEN_W'(1);
                            if (last_in) begin
                                r_state     <= HOLD;
                                r_valid_out <= 1'b1;
                            end else if (MAX_LEN == 1) begin
                                r_state <= DROP;
                            end
                        end
`endif
                    end
                end

                default: begin
                    r_state <= ACC;
                end
            endcase
        end
    end

    assign ready_in  = w_ready_in;
    assign valid_out = r_valid_out;
    assign data_out  = r_word;
    assign len_out   = r_count;
    assign err_out   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pkt_deser.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pkt_deser
//  Description : Self-checking bench for pkt_deser. Packets from a vector
//                table are serialised into the DUT; expected words are queued
//                when driven and compared when the DUT fires its output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pkt_deser;

    localparam int c_MAX_LEN = 8;
    localparam int c_LEN_W   = 4;

    logic                 clk;
    logic                 rst;
    logic                 valid_in;
    logic                 data_in;
    logic                 last_in;
    logic                 ready_in;
    logic                 valid_out;
    logic [c_MAX_LEN-1:0] data_out;
    logic [c_LEN_W-1:0]   len_out;
    logic                 err_out;
    logic                 ready_out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] bits;
        int          n;
        bit          gap;
        logic [7:0]  exp_data;
        logic [3:0]  exp_len;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        logic       err;
    } exp_t;

    exp_t q_exp[$];

    pkt_deser #(.MAX_LEN(c_MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .last_in   (last_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .len_out   (len_out),
        .err_out   (err_out),
        .ready_out (ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare each consumed word against the oldest expectation
    always @(negedge clk) begin
        if (!rst && valid_out && ready_out) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_word", 1, 0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("word_data", int'(data_out), int'(e.data));
                chk("word_len",  int'(len_out),  int'(e.len));
                chk("word_err",  int'(err_out),  int'(e.err));
            end
        end
    end

    // Serialise n beats LSB first; stalls counts negedges that saw ready_in low
    task automatic send_pkt(input logic [15:0] bits, input int n, input bit use_last,
                            input bit gap, output int stalls);
        stalls = 0;
        for (int b = 0; b < n; b++) begin
            int t;
            logic [15:0] v;
            v        = bits;
            valid_in = 1'b1;
            data_in  = v[b];
            last_in  = use_last && (b == n - 1);
            t        = 0;
            @(negedge clk);
            while (!ready_in && t < 100) begin
                stalls++;
                t++;
                @(negedge clk);
            end
            if (t >= 100) chk("beat_accept_timeout", 1, 0);
            @(posedge clk);
            #1;
            if (gap && b != n - 1) begin
                valid_in = 1'b0;
                data_in  = 1'b1;
                last_in  = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        valid_in = 1'b0;
        last_in  = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((q_exp.size() != 0 || valid_out) && t < 200) begin
            t++;
            @(negedge clk);
        end
        chk("drain_timeout", int'(t >= 200), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic [3:0] l, input logic e);
        exp_t x;
        x.data = d;
        x.len  = l;
        x.err  = e;
        q_exp.push_back(x);
    endtask

    initial begin
        vec_t vecs[7];
        int   stalls;

        vecs[0] = '{16'h004D, 8,  1'b0, 8'h4D, 4'd8, 1'b0};
        vecs[1] = '{16'h0003, 3,  1'b0, 8'h03, 4'd3, 1'b0};
        vecs[2] = '{16'h03FF, 10, 1'b0, 8'hFF, 4'd8, 1'b1};
        vecs[3] = '{16'h0001, 1,  1'b0, 8'h01, 4'd1, 1'b0};
        vecs[4] = '{16'h0000, 1,  1'b0, 8'h00, 4'd1, 1'b0};
        vecs[5] = '{16'h0155, 9,  1'b1, 8'h55, 4'd8, 1'b1};
        vecs[6] = '{16'h005A, 7,  1'b1, 8'h5A, 4'd7, 1'b0};

        rst       = 1'b1;
        valid_in  = 1'b0;
        data_in   = 1'b0;
        last_in   = 1'b0;
        ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_valid_out", int'(valid_out), 0);
        chk("reset_data_out",  int'(data_out),  0);
        chk("reset_len_out",   int'(len_out),   0);
        chk("reset_err_out",   int'(err_out),   0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready_in", int'(ready_in), 1);
        @(posedge clk);
        #1;

        // Table-driven packets
        foreach (vecs[i]) begin
            push(vecs[i].exp_data, vecs[i].exp_len, vecs[i].exp_err);
            send_pkt(vecs[i].bits, vecs[i].n, 1'b1, vecs[i].gap, stalls);
        end
        drain();

        // Overflow packet must see ready_in high for every beat incl. 9 and 10
        push(8'hFF, 4'd8, 1'b1);
        send_pkt(16'h03FF, 10, 1'b1, 1'b0, stalls);
        chk("overflow_no_stall", stalls, 0);
        drain();

        // Backpressure: word held stable for 5 cycles, then one fire
        ready_out = 1'b0;
        push(8'h03, 4'd3, 1'b0);
        send_pkt(16'h0003, 3, 1'b1, 1'b0, stalls);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_valid_out", int'(valid_out), 1);
            chk("hold_data_out",  int'(data_out),  8'h03);
            chk("hold_len_out",   int'(len_out),   3);
            chk("hold_err_out",   int'(err_out),   0);
            chk("hold_ready_in",  int'(ready_in),  0);
            @(posedge clk);
            #1;
        end
        ready_out = 1'b1;
        @(negedge clk);
        chk("fire_valid_out", int'(valid_out), 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_fire_valid_out", int'(valid_out), 0);
        chk("post_fire_ready_in",  int'(ready_in),  1);
        chk("post_fire_queue",     q_exp.size(),    0);
        @(posedge clk);
        #1;

        // Reset mid-packet discards the partial packet
        send_pkt(16'h000F, 4, 1'b0, 1'b0, stalls);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_valid_out", int'(valid_out), 0);
        chk("midrst_len_out",   int'(len_out),   0);
        chk("midrst_data_out",  int'(data_out),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(8'h03, 4'd2, 1'b0);
        send_pkt(16'h0003, 2, 1'b1, 1'b0, stalls);
        drain();

        // Two back-to-back 8-beat packets with continuous valid_in
        begin
            int s1, s2;
            push(8'hA5, 4'd8, 1'b0);
            push(8'h3C, 4'd8, 1'b0);
            send_pkt(16'h00A5, 8, 1'b1, 1'b0, s1);
            send_pkt(16'h003C, 8, 1'b1, 1'b0, s2);
`ifdef PKT_DESER_B2B_EN
            chk("b2b_no_bubble", s1 + s2, 0);
`else
            chk("nob2b_bubble", int'(s2 >= 1), 1);
`endif
            drain();
        end

        chk("final_queue_empty", q_exp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
